// File: rtl/ac_pkg.sv
// Shared AC_Controller definitions: the temperature comparison codes carried on temp_comp.
package ac_pkg;

  typedef enum logic [1:0] {
    TC_EQUAL  = 2'b00,
    TC_LOWER  = 2'b01,
    TC_HIGHER = 2'b10
  } temp_comp_e;

endpackage

// File: rtl/temp_comp_gen_if.sv
// Sensor/button inputs and comparison outputs of temp_comp_gen.
interface temp_comp_gen_if
  import ac_pkg::*;
#(
  parameter int W = 8
);

  logic         sample_valid;
  logic [W-1:0] temp_meas;
  logic         sp_up;
  logic         sp_down;
  logic [W-1:0] setpoint;
  logic         avg_valid;
  temp_comp_e   temp_comp;

  modport master (
    output sample_valid, temp_meas, sp_up, sp_down,
    input  setpoint, avg_valid, temp_comp
  );

  modport slave (
    input  sample_valid, temp_meas, sp_up, sp_down,
    output setpoint, avg_valid, temp_comp
  );

endinterface

// File: rtl/temp_moving_avg.sv
// 4-sample moving average of raw temperature samples; avg_valid once the window is full.
module temp_moving_avg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_valid,
  input  logic [W-1:0] sample,
  output logic [W-1:0] avg,
  output logic         avg_valid
);

  logic [3:0][W-1:0] window;
  logic [W+1:0]      sum;
  logic [W+1:0]      sum_next;
  logic [1:0]        fill;

  // Sum always contains window[3], so the subtraction never underflows.
  assign sum_next = sum + {2'b00, sample} - {2'b00, window[3]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the window is real state (it seeds the partial sums), so it is reset like any register.
      window    <= '0;
      sum       <= '0;
      avg       <= '0;
      fill      <= '0;
      avg_valid <= 1'b0;
    end else if (sample_valid) begin
      window    <= {window[2:0], sample};
      sum       <= sum_next;
      avg       <= sum_next[W+1:2];
      if (fill == 2'd3) avg_valid <= 1'b1;
      else              fill      <= fill + 2'd1;
    end
  end

endmodule

// File: rtl/temp_comp_gen.sv
// Setpoint register, hysteresis classifier and debounce FSM producing temp_comp for AC_Controller.
module temp_comp_gen
  import ac_pkg::*;
#(
  parameter int W       = 8,
  parameter int HYST    = 2,
  parameter int STABLE  = 3,
  parameter int SP_INIT = 22,
  parameter int SP_MIN  = 16,
  parameter int SP_MAX  = 30
) (
  input logic            clk,
  input logic            reset,
  temp_comp_gen_if.slave bus
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic signed [W+1:0] HYST_S = (W+2)'(HYST);
  localparam logic [W-1:0] SP_INIT_W = W'(SP_INIT);
  localparam logic [W-1:0] SP_MIN_W  = W'(SP_MIN);
  localparam logic [W-1:0] SP_MAX_W  = W'(SP_MAX);
  localparam logic [CW-1:0] STABLE_W = CW'(STABLE);

  logic [W-1:0]         avg;
  logic                 avg_valid;
  logic                 eval_q;
  logic [W-1:0]         sp;
  temp_comp_e           cur;
  temp_comp_e           last_c;
  temp_comp_e           cand;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_next;
  logic signed [W+1:0]  avg_s;
  logic signed [W+1:0]  sp_s;
  logic                 above_band;
  logic                 below_band;

  temp_moving_avg #(.W(W)) u_avg (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (bus.sample_valid),
    .sample       (bus.temp_meas),
    .avg          (avg),
    .avg_valid    (avg_valid)
  );

  // Two extra bits keep sp+HYST and sp-HYST from wrapping at either end of the range.
  assign avg_s      = signed'({2'b00, avg});
  assign sp_s       = signed'({2'b00, sp});
  assign above_band = avg_s > (sp_s + HYST_S);
  assign below_band = avg_s < (sp_s - HYST_S);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cand     = TC_EQUAL;
    cnt_next = '0;
    case (cur)
      TC_HIGHER: cand = (avg_s > sp_s) ? TC_HIGHER : (below_band ? TC_LOWER : TC_EQUAL);
      TC_LOWER:  cand = (avg_s < sp_s) ? TC_LOWER : (above_band ? TC_HIGHER : TC_EQUAL);
      default:   cand = above_band ? TC_HIGHER : (below_band ? TC_LOWER : TC_EQUAL);
    endcase
    if (cand == cur)         cnt_next = '0;
    else if (cand != last_c) cnt_next = CW'(1);
    else                     cnt_next = cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
      sp     <= SP_INIT_W;
      cur    <= TC_EQUAL;
      last_c <= TC_EQUAL;
      cnt    <= '0;
      eval_q <= 1'b0;
    end else begin
      eval_q <= bus.sample_valid;
      if (bus.sp_up && !bus.sp_down && sp < SP_MAX_W)      sp <= sp + 1'b1;
      else if (bus.sp_down && !bus.sp_up && sp > SP_MIN_W) sp <= sp - 1'b1;
      // One evaluation per accepted sample, using the average registered on the previous edge.
      if (eval_q && avg_valid) begin
        last_c <= cand;
        if (cnt_next == STABLE_W) begin
          cur <= cand;
          cnt <= '0;
        end else begin
          cnt <= cnt_next;
        end
      end
    end
  end

  assign bus.setpoint  = sp;
  assign bus.avg_valid = avg_valid;
  assign bus.temp_comp = cur;

endmodule
